// File: rtl/reg_writeback_arbiter.sv
// Writeback arbiter: merges the ALU result path and a FIFO-buffered long-latency path
// onto the single register-bank write port, and flags queued writes to read addresses.
module reg_writeback_arbiter #(
   parameter int DEPTH   = 4,
   parameter int AW      = 5,
   parameter int DW      = 32,
   parameter bit DROP_R0 = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     alu_valid,
   input  logic [AW-1:0]            alu_addr,
   input  logic [DW-1:0]            alu_data,
   input  logic                     ext_valid,
   output logic                     ext_ready,
   input  logic [AW-1:0]            ext_addr,
   input  logic [DW-1:0]            ext_data,
   input  logic [AW-1:0]            regAddr_1,
   input  logic [AW-1:0]            regAddr_2,
   output logic                     pend_hit_1,
   output logic                     pend_hit_2,
   output logic                     regWriteEnable,
   output logic [AW-1:0]            regWriteAddr,
   output logic [DW-1:0]            regWriteData,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     overflow_err
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [AW-1:0] mem_addr [DEPTH];
   logic [DW-1:0] mem_data [DEPTH];
   logic [DEPTH-1:0] vld;
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;

   logic full, empty, push, pop, alu_go;

   assign full      = (count == CW'(DEPTH));
   assign empty     = (count == '0);
   assign ext_ready = !full;
   assign alu_go    = alu_valid && !(DROP_R0 && (alu_addr == '0));
   // A dropped r0 handshake still completes: ready is honoured, nothing is stored.
   assign push      = ext_valid && ext_ready && !(DROP_R0 && (ext_addr == '0));
   assign pop       = !alu_go && !empty;
   assign fifo_count = count;

   // Popped entries leave vld at the same edge they land on the write port.
   always_comb begin
      pend_hit_1 = 1'b0;
      pend_hit_2 = 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (vld[i] && (mem_addr[i] == regAddr_1)) pend_hit_1 = 1'b1;
         if (vld[i] && (mem_addr[i] == regAddr_2)) pend_hit_2 = 1'b1;
      end
      if (DROP_R0 && (regAddr_1 == '0)) pend_hit_1 = 1'b0;
      if (DROP_R0 && (regAddr_2 == '0)) pend_hit_2 = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         count          <= '0;
         vld            <= '0;
         regWriteEnable <= 1'b0;
         regWriteAddr   <= '0;
         regWriteData   <= '0;
         overflow_err   <= 1'b0;
      end else begin
         if (push && full) overflow_err <= 1'b1;

         if (push) begin
            mem_addr[wr_ptr] <= ext_addr;
            mem_data[wr_ptr] <= ext_data;
            vld[wr_ptr]      <= 1'b1;
            wr_ptr           <= wr_ptr + 1'b1;
         end
         if (pop) begin
            vld[rd_ptr] <= 1'b0;
            rd_ptr      <= rd_ptr + 1'b1;
         end

         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase

         regWriteEnable <= alu_go || pop;
         if (alu_go) begin
            regWriteAddr <= alu_addr;
            regWriteData <= alu_data;
         end else if (pop) begin
            regWriteAddr <= mem_addr[rd_ptr];
            regWriteData <= mem_data[rd_ptr];
         end
      end
   end

endmodule
